// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter
// Shares RAM port A between two requesters (m0 = CPU, m1 = DMA/text engine).
// Every access is a fixed four-state transaction: IDLE -> ADDR -> DATA -> ACK.
// Ties are resolved round-robin, or always in favour of m0 when FIXED_PRIO=1.
// Every output comes straight from a flop.
module mem_port_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    ACK  = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic                last_m1, last_m1_nxt;   // last transaction went to m1
  logic                xfer_we, xfer_we_nxt;   // current transaction is a write
  logic                pick_m1;
  logic [1:0]          grant_nxt;
  logic                mem_we_nxt;
  logic [ADDR_W-1:0]   mem_addr_nxt;
  logic [DATA_W-1:0]   mem_din_nxt;
  logic                m0_ack_nxt, m1_ack_nxt;
  logic [DATA_W-1:0]   m0_rdata_nxt, m1_rdata_nxt;

  // Winner selection: a lone requester wins; on a tie, either m0 (fixed) or
  // whoever was not served last (round-robin).
  always_comb begin
    if (m0_req && m1_req) begin
      pick_m1 = (FIXED_PRIO == 0) && !last_m1;
    end else begin
      pick_m1 = m1_req;
    end
  end

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    // NOTE: every target gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_nxt    = state;
    last_m1_nxt  = last_m1;
    xfer_we_nxt  = xfer_we;
    grant_nxt    = grant;
    mem_we_nxt   = 1'b0;
    mem_addr_nxt = mem_addr;
    mem_din_nxt  = mem_din;
    m0_ack_nxt   = 1'b0;
    m1_ack_nxt   = 1'b0;
    m0_rdata_nxt = m0_rdata;
    m1_rdata_nxt = m1_rdata;

    case (state)
      IDLE: begin
        if (enable && (m0_req || m1_req)) begin
          state_nxt    = ADDR;
          last_m1_nxt  = pick_m1;
          grant_nxt    = pick_m1 ? 2'b10 : 2'b01;
          xfer_we_nxt  = pick_m1 ? m1_we : m0_we;
          mem_we_nxt   = pick_m1 ? m1_we : m0_we;
          mem_addr_nxt = pick_m1 ? m1_addr : m0_addr;
          mem_din_nxt  = pick_m1 ? m1_wdata : m0_wdata;
        end
      end
      ADDR: begin
        // RAM samples address/data at the end of this cycle.
        state_nxt = DATA;
      end
      DATA: begin
        // Read data is valid now; capture it for the owner only.
        state_nxt = ACK;
        if (!xfer_we) begin
          if (grant[1]) begin
            m1_rdata_nxt = mem_dout;
          end else begin
            m0_rdata_nxt = mem_dout;
          end
        end
        m0_ack_nxt = grant[0];
        m1_ack_nxt = grant[1];
      end
      ACK: begin
        // Requests are ignored here so a requester can drop req after its ack.
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

  // State register and registered outputs; reset aborts any transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last_m1  <= 1'b1;
      xfer_we  <= 1'b0;
      grant    <= 2'b00;
      busy     <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values,
      // so ordering inside this block cannot change behaviour.
      state    <= state_nxt;
      last_m1  <= last_m1_nxt;
      xfer_we  <= xfer_we_nxt;
      grant    <= grant_nxt;
      busy     <= (state_nxt != IDLE);
      mem_we   <= mem_we_nxt;
      mem_addr <= mem_addr_nxt;
      mem_din  <= mem_din_nxt;
      m0_ack   <= m0_ack_nxt;
      m1_ack   <= m1_ack_nxt;
      m0_rdata <= m0_rdata_nxt;
      m1_rdata <= m1_rdata_nxt;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single read/write port A of the 32 Kword RAM between two requesters: m0 (CPU load/store/fetch) and m1 (DMA / text-screen engine).
- Port B stays dedicated to VGA readout.
- Sits between the requesters and the RAM port A pins (we, addr, data_in, data_out).
- Sequences each access as a fixed 4-state transaction with a req/ack handshake and round-robin or fixed-priority arbitration.

Parameters:
- ADDR_W, 15, word address width of RAM port A.
- DATA_W, 16, data width.
- FIXED_PRIO, 0, 0 = round-robin between m0/m1; 1 = m0 always wins ties.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- enable  input  1  arbiter may start new transactions when high
- m0_req  input  1  m0 access request, held until m0_ack
- m0_we  input  1  1 = write, 0 = read
- m0_addr  input  ADDR_W  m0 word address
- m0_wdata  input  DATA_W  m0 write data
- m0_ack  output  1  one-cycle completion pulse
- m0_rdata  output  DATA_W  read data, valid with m0_ack, held until next m0 read completes
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same as m0, for m1
- mem_we  output  1  to RAM port A write enable
- mem_addr  output  ADDR_W  to RAM port A address
- mem_din  output  DATA_W  to RAM port A write data
- mem_dout  input  DATA_W  from RAM port A, valid one cycle after address is sampled
- grant  output  2  one-hot owner of current transaction (bit0 = m0); 0 when idle
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - grant, busy, m0_ack, m1_ack and mem_we go to 0.
  - mem_addr, mem_din, m0_rdata and m1_rdata go to 0.
  - The last-granted pointer goes to m1, so m0 wins the first tie.
- Reset mid-transaction: the transaction is aborted immediately. No ack is issued afterwards, and a write already clocked into the RAM is not undone.
- All outputs are registered.
- FSM states: IDLE -> ADDR -> DATA -> ACK -> IDLE.
- IDLE:
  - If enable=1 and any req=1, select a winner.
  - Latch the winner's we/addr/wdata into mem_we/mem_addr/mem_din, set grant, go to ADDR.
  - If nothing is selected, stay in IDLE with mem_we=0.
- Winner selection:
  - Only one req: that requester wins.
  - Both req with FIXED_PRIO=1: m0 wins.
  - Both req with FIXED_PRIO=0: the requester not granted last wins. The pointer updates on entry to ADDR.
- ADDR: mem_* outputs are valid for exactly this cycle. mem_we is high only here, and only for writes. RAM samples at the end of the cycle. Go to DATA.
- DATA:
  - mem_we=0.
  - mem_dout is valid. For a read, capture it into the owner's rdata at the end of the cycle.
  - Set the owner's ack for the next cycle. Go to ACK.
- ACK:
  - Owner's ack=1 for exactly one cycle.
  - req lines are ignored this cycle; the requester drops req here if done.
  - Next cycle go to IDLE, clear grant and ack.
- Latency and throughput:
  - Request sampled at edge 0, ack high in cycle 3.
  - Maximum throughput is one access per 4 cycles.
  - The non-owner's ack never pulses.
- Write transactions still pulse ack. rdata is unchanged on writes.
- Non-IDLE states: mem_addr and mem_din hold their last values.
- enable low:
  - Blocks new grants only; an in-flight transaction completes normally.
  - enable rising in the same cycle as req: the grant is taken that cycle.
- req must stay stable from assertion to ack. Changes to a non-granted requester's signals are harmless.
- req dropped before ack: the transaction still completes with the latched values.
- Address wrap: none. Addresses pass through unmodified over the full 0..2^ADDR_W-1 range.

Test Plan:
- Reset then single read: preload RAM[0x2005]=0xBEEF; m0_req=1, we=0, addr=0x2005 at edge 0 -> mem_addr=0x2005 in cycle 1; m0_ack=1 and m0_rdata=0xBEEF in cycle 3 only; m1_ack stays 0.
- Write then readback via m1: write 0x1234 to 0x0100 -> mem_we=1 for exactly one cycle; a following m1 read of 0x0100 returns 0x1234; m1_rdata unchanged after the write ack.
- Round-robin contention (FIXED_PRIO=0): m0 and m1 both hold req continuously for 4 transactions -> grant order m0, m1, m0, m1; acks 4 cycles apart. With FIXED_PRIO=1 -> m0 wins all four.
- enable gating: enable=0 with m1_req=1 for 10 cycles -> busy=0, no mem_we; enable->1 -> ADDR next cycle and ack 3 cycles later. Dropping enable mid-transaction -> that ack still arrives.
- Asynchronous reset in DATA state of a read: all outputs are 0 immediately (no clock edge needed); no ack appears afterwards; a fresh request after reset release completes normally with 3-cycle latency.
- Boundary addresses: reads/writes at 0x0000 and 0x7FFF round-trip correctly; back-to-back m0 requests with req held through ACK -> the second transaction starts at IDLE, 4 cycles after the first.
